ram_fifo_line_writer: RTL

Write-side controller for the scaler's RAM line-buffer FIFO. It accepts an incoming pixel stream with a valid/ready handshake and writes one video line per buffer RAM. It generates the FIFO's writeData/writeAddress/writeEnable/advanceWrite/forceRead inputs and applies backpressure from the FIFO's fillCount. It sits between the input video front end and the line buffer, whose read side is driven by the scaler core.

---
 rtl/ram_fifo_line_writer.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_fifo_line_writer.sv
// ram_fifo_line_writer: writes one video line per line-buffer RAM, with fillCount backpressure
module ram_fifo_line_writer #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDRESS_WIDTH     = 8,
    parameter int BUFFER_SIZE       = 4,
    parameter int BUFFER_SIZE_WIDTH = 3,
    parameter int Y_RES_WIDTH       = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH-1:0]     inputXRes,
    input  logic [Y_RES_WIDTH-1:0]       inputYRes,
    input  logic [DATA_WIDTH-1:0]        dIn,
    input  logic                         dInValid,
    output logic                         nextDin,
    input  logic [BUFFER_SIZE_WIDTH-1:0] fillCount,
    output logic [DATA_WIDTH-1:0]        writeData,
    output logic [ADDRESS_WIDTH-1:0]     writeAddress,
    output logic                         writeEnable,
    output logic                         advanceWrite,
    output logic                         forceRead,
    output logic                         frameDone
);
    typedef enum logic [2:0] {IDLE, WAIT_SPACE, WRITE, SETTLE, DONE} state_t;
    localparam logic [BUFFER_SIZE_WIDTH-1:0] FULL = BUFFER_SIZE_WIDTH'(BUFFER_SIZE);
    state_t state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] x_q, x_d, xres_q, xres_d, waddr_q, waddr_d;
    logic [Y_RES_WIDTH-1:0] y_q, y_d, yres_q, yres_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic we_q, we_d, adv_q, adv_d, fr_q, fr_d, fd_q, fd_d;
    logic xfer;
    // Ready depends only on state and start so a start cycle never accepts a pixel
    assign nextDin = (state_q == WRITE) && !start;
    assign xfer = dInValid && nextDin;
    assign writeData = wdata_q;
    assign writeAddress = waddr_q;
    assign writeEnable = we_q;
    assign advanceWrite = adv_q;
    assign forceRead = fr_q;
    assign frameDone = fd_q;
    // Next-state: start overrides everything; the last pixel of a line raises advance with its write
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        xres_d = xres_q;
        yres_d = yres_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        we_d = 1'b0;
        adv_d = 1'b0;
        fd_d = 1'b0;
        fr_d = state_q == DONE;
        if (start) begin
            state_d = WAIT_SPACE;
            x_d = '0;
            y_d = '0;
            xres_d = inputXRes;
            yres_d = inputYRes;
            fr_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_SPACE: state_d = fillCount < FULL ? WRITE : WAIT_SPACE;
                WRITE: if (xfer) begin
                    wdata_d = dIn;
                    waddr_d = x_q;
                    we_d = 1'b1;
                    x_d = x_q + ADDRESS_WIDTH'(1);
                    if (x_q == xres_q) begin
                        x_d = '0;
                        adv_d = 1'b1;
                        if (y_q == yres_q) begin
                            state_d = DONE;
                            fd_d = 1'b1;
                        end else begin
                            y_d = y_q + Y_RES_WIDTH'(1);
                            state_d = SETTLE;
                        end
                    end
                end
                SETTLE: state_d = WAIT_SPACE;
                default: ;
            endcase
        end
    end
    // State and registered outputs, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            xres_q <= '0;
            yres_q <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q <= 1'b0;
            adv_q <= 1'b0;
            fr_q <= 1'b0;
            fd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            xres_q <= xres_d;
            yres_q <= yres_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            we_q <= we_d;
            adv_q <= adv_d;
            fr_q <= fr_d;
            fd_q <= fd_d;
        end
    end
endmodule
